alu_control_sequencer: RTL and testbench
========================================

Name: alu_control_sequencer

Overview:
- Parametrised control unit for the single-bus datapath. It generates per-step control strobes for fetch plus register-register ALU instructions, replacing hand-sequenced T0..T5 stimulus.
- Drives the bus select/enable lines, ALU operation code and memory read handshake. Decodes IR fields into one-hot register in/out vectors.
- Adds memory wait states, a two-step Z write-back for MUL/DIV, HALT, and illegal-opcode detection.

Parameters:
- NUM_REGS, 16, general registers; the reg_in/reg_out vector width.
- REG_IDX_W, 4, register index field width; NUM_REGS <= 2**REG_IDX_W.
- OPCODE_W, 5, opcode field width; equals the operation port width.
- INSTR_W, 32, IR width. Opcode at [INSTR_W-1 -: OPCODE_W], then Ra, Rb, Rc each REG_IDX_W wide, packed downward.

Ports:
- clock in 1: rising-edge clock.
- clear in 1: synchronous reset, active-low.
- ir in INSTR_W: IR register contents.
- mem_ready in 1: memory has data valid on Mdatain this cycle.
- reg_in out NUM_REGS: one-hot register load enables.
- reg_out out NUM_REGS: one-hot register bus drives.
- PCout, PCin, IncPC, MARin, MDRin, MDRout, IRin, Yin, Zlowin, Zhighin, ZLOout, ZHIout, HIin, LOin out 1 each: datapath strobes.
- read out 1: memory read request.
- operation out OPCODE_W: ALU operation select.
- run out 1: high unless halted.
- illegal_op out 1: one-cycle pulse on an undefined opcode.
- state_q out 4: current state, for debug.

Behaviour:
- Moore FSM. All outputs are registered and decoded from the next state, so strobes are valid for the whole cycle the state occupies.
- Opcode set (pkg): ADD 00011, AND 00100, OR 00101, SUB 00110, MUL 01111, DIV 10000, NOP 11010, HALT 11011.
- States and actions:
  - RST: all outputs 0, run=1.
  - T0: PCout, MARin, IncPC, Zlowin.
  - T1: ZLOout, PCin, read, MDRin. Stay in T1 while mem_ready=0; all T1 strobes stay high during the stall. PC is only written once, because Z does not change during the stall.
  - T2: MDRout, IRin.
  - T3: decode the IR value latched in T2, i.e. ir as seen in T3. reg_out[Rb], Yin.
  - T4: reg_out[Rc], operation=opcode, Zlowin. Zhighin is also asserted for MUL/DIV.
  - T5: ZLOout plus reg_in[Ra]; for MUL/DIV, ZLOout plus LOin instead.
  - T6 (MUL/DIV only): ZHIout, HIin.
  - HALT: all strobes 0, run=0.
- Transitions:
  - RST to T0.
  - T0 to T1.
  - T1 to T2 when mem_ready=1.
  - T2 to T3.
  - T3: to T0 for NOP; to HALT for HALT; to T0 with illegal_op=1 for an undefined opcode, with no register written; otherwise to T4.
  - T4 to T5.
  - T5 to T6 for MUL/DIV, else to T0.
  - T6 to T0.
  - HALT is absorbing until reset.
- Register index rules:
  - An index >= NUM_REGS gives an all-zero vector, not an illegal op.
  - reg_in and reg_out are each at most one-hot.
  - At most one bus driver is asserted in any cycle.
- operation holds its last value outside T4 and resets to 0.
- Reset: clear=0 at any edge forces RST on that edge. This holds mid-fetch, during a T1 stall, or in HALT. All outputs are 0 the following cycle, except run=1.
- Latency: ALU op is 6 cycles plus wait states. MUL/DIV is 7 cycles plus wait states.

Optional Feature:
- Macro ALU_SEQ_SINGLE_STEP_EN.
- When defined:
  - Adds input step (1 bit).
  - FSM enters WAIT_STEP instead of T0 at instruction end (from T3, T5, T6); all strobes are 0 there.
  - Leaves WAIT_STEP for T0 on the cycle after step=1 is sampled.
  - RST also goes to WAIT_STEP.
- When undefined: no step port and no WAIT_STEP state.

Decomposition:
- Package alu_seq_pkg: opcode localparams, state encoding enum (4-bit), field-offset helper functions.
- One sub-module, idx_decoder: parametrised REG_IDX_W to NUM_REGS one-hot with an enable input. It is instantiated twice, for in and for out.

Test Plan:
- AND R0,R4,R5: ir=0x20228000, mem_ready tied 1. Expect:
  - T3: reg_out=0x0010, Yin.
  - T4: reg_out=0x0020, operation=00100, Zlowin.
  - T5: ZLOout, reg_in=0x0001.
  - Back in T0 6 cycles after T0 entry.
- MUL R1,R2,R3 (opcode 01111). Expect Zlowin and Zhighin in T4, LOin in T5, ZHIout and HIin in T6, and no reg_in asserted throughout.
- mem_ready held low for 3 cycles in T1. Expect T1 held 4 cycles with read=MDRin=PCin=1 throughout and IRin only after mem_ready=1.
- clear=0 during a T1 stall, then during T4. Expect state RST and all strobes 0 next cycle, then a clean T0.
- Opcode 11111: illegal_op pulses exactly 1 cycle at T3 exit, no reg_in, next state T0. HALT opcode: run drops to 0 and stays there for 20 cycles.
- ALU_SEQ_SINGLE_STEP_EN defined: no T0 until step is pulsed; each step pulse executes exactly one ADD.

Source files
------------

// File: rtl/alu_seq_pkg.sv
// Shared opcode values, sequencer state encoding, strobe bundle and IR field helpers
// for the single-bus ALU control sequencer.
package alu_seq_pkg;

  localparam logic [4:0] OP_ADD  = 5'b00011;
  localparam logic [4:0] OP_AND  = 5'b00100;
  localparam logic [4:0] OP_OR   = 5'b00101;
  localparam logic [4:0] OP_SUB  = 5'b00110;
  localparam logic [4:0] OP_MUL  = 5'b01111;
  localparam logic [4:0] OP_DIV  = 5'b10000;
  localparam logic [4:0] OP_NOP  = 5'b11010;
  localparam logic [4:0] OP_HALT = 5'b11011;

  typedef enum logic [3:0] {
    ST_RST       = 4'd0,
    ST_T0        = 4'd1,
    ST_T1        = 4'd2,
    ST_T2        = 4'd3,
    ST_T3        = 4'd4,
    ST_T4        = 4'd5,
    ST_T5        = 4'd6,
    ST_T6        = 4'd7,
    ST_HALT      = 4'd8,
    ST_WAIT_STEP = 4'd9
  } seq_state_e;

  typedef struct packed {
    logic pc_out;
    logic pc_in;
    logic inc_pc;
    logic mar_in;
    logic mdr_in;
    logic mdr_out;
    logic ir_in;
    logic y_in;
    logic zlow_in;
    logic zhigh_in;
    logic zlo_out;
    logic zhi_out;
    logic hi_in;
    logic lo_in;
    logic read;
  } seq_strobes_t;

  function automatic int opcode_lsb(input int instr_w, input int opcode_w);
    return instr_w - opcode_w;
  endfunction

  // slot 0 = Ra, 1 = Rb, 2 = Rc, packed downward under the opcode
  function automatic int reg_field_lsb(input int instr_w, input int opcode_w,
                                       input int idx_w, input int slot);
    return instr_w - opcode_w - (slot + 1) * idx_w;
  endfunction

endpackage

// File: rtl/alu_control_sequencer_idx_decoder.sv
// Register index to one-hot enable vector; indices past NUM_REGS decode to all zeros.
module idx_decoder #(
  parameter int REG_IDX_W = 4,
  parameter int NUM_REGS  = 16
) (
  input  logic [REG_IDX_W-1:0] idx,
  input  logic                 en,
  output logic [NUM_REGS-1:0]  onehot
);

  always_comb begin
    onehot = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (en && (idx == REG_IDX_W'(i))) onehot[i] = 1'b1;
    end
  end

endmodule

// File: rtl/alu_control_sequencer.sv
// Moore control sequencer for fetch plus register-register ALU instructions.
// Optional single-step mode: define ALU_SEQ_SINGLE_STEP_EN.
//
// state     | meaning
// ----------+-----------------------------------------------
// RST       | after clear, all strobes 0, run=1
// T0        | PC onto bus, MAR load, PC increment into Z
// T1        | Z low to PC, memory read into MDR (stall here)
// T2        | MDR to IR
// T3        | Rb onto bus into Y, opcode decode
// T4        | Rc onto bus, ALU op into Z
// T5        | Z low into Ra, or into LO for MUL/DIV
// T6        | Z high into HI (MUL/DIV only)
// HALT      | absorbing, run=0
// WAIT_STEP | idle between instructions until step (optional)
module alu_control_sequencer
  import alu_seq_pkg::*;
#(
  parameter int NUM_REGS  = 16,
  parameter int REG_IDX_W = 4,
  parameter int OPCODE_W  = 5,
  parameter int INSTR_W   = 32
) (
  input  logic                 clock,
  input  logic                 clear,
  input  logic [INSTR_W-1:0]   ir,
  input  logic                 mem_ready,
`ifdef ALU_SEQ_SINGLE_STEP_EN
  input  logic                 step,
`endif
  output logic [NUM_REGS-1:0]  reg_in,
  output logic [NUM_REGS-1:0]  reg_out,
  output logic                 PCout,
  output logic                 PCin,
  output logic                 IncPC,
  output logic                 MARin,
  output logic                 MDRin,
  output logic                 MDRout,
  output logic                 IRin,
  output logic                 Yin,
  output logic                 Zlowin,
  output logic                 Zhighin,
  output logic                 ZLOout,
  output logic                 ZHIout,
  output logic                 HIin,
  output logic                 LOin,
  output logic                 read,
  output logic [OPCODE_W-1:0]  operation,
  output logic                 run,
  output logic                 illegal_op,
  output logic [3:0]           state_q
);

  localparam int OP_LSB = opcode_lsb(INSTR_W, OPCODE_W);
  localparam int RA_LSB = reg_field_lsb(INSTR_W, OPCODE_W, REG_IDX_W, 0);
  localparam int RB_LSB = reg_field_lsb(INSTR_W, OPCODE_W, REG_IDX_W, 1);
  localparam int RC_LSB = reg_field_lsb(INSTR_W, OPCODE_W, REG_IDX_W, 2);

`ifdef ALU_SEQ_SINGLE_STEP_EN
  localparam seq_state_e END_STATE = ST_WAIT_STEP;
`else
  localparam seq_state_e END_STATE = ST_T0;
`endif

  logic [OPCODE_W-1:0]  opcode;
  logic [REG_IDX_W-1:0] ra_idx, rb_idx, rc_idx, out_idx;
  logic                 is_muldiv, is_nop, is_halt, is_legal;

  seq_state_e   cur_state, nxt_state;
  seq_strobes_t strb_q, strb_d;
  logic         rb_drv_q, rc_drv_q, ra_load_q;

  assign opcode = ir[OP_LSB +: OPCODE_W];
  assign ra_idx = ir[RA_LSB +: REG_IDX_W];
  assign rb_idx = ir[RB_LSB +: REG_IDX_W];
  assign rc_idx = ir[RC_LSB +: REG_IDX_W];

  generate
    if (RC_LSB > 0) begin : g_spare_bits
      logic unused_ir_low;
      assign unused_ir_low = ^ir[RC_LSB-1:0];
    end
  endgenerate

  assign is_muldiv = (opcode == OPCODE_W'(OP_MUL)) || (opcode == OPCODE_W'(OP_DIV));
  assign is_nop    = (opcode == OPCODE_W'(OP_NOP));
  assign is_halt   = (opcode == OPCODE_W'(OP_HALT));
  assign is_legal  = is_muldiv || is_nop || is_halt ||
                     (opcode == OPCODE_W'(OP_ADD)) || (opcode == OPCODE_W'(OP_AND)) ||
                     (opcode == OPCODE_W'(OP_OR))  || (opcode == OPCODE_W'(OP_SUB));

  always_comb begin
    nxt_state = cur_state;
    case (cur_state)
      ST_RST:  nxt_state = END_STATE;
      ST_T0:   nxt_state = ST_T1;
      ST_T1:   if (mem_ready) nxt_state = ST_T2;
      ST_T2:   nxt_state = ST_T3;
      ST_T3: begin
        if (is_halt)                nxt_state = ST_HALT;
        else if (is_nop || !is_legal) nxt_state = END_STATE;
        else                        nxt_state = ST_T4;
      end
      ST_T4:   nxt_state = ST_T5;
      ST_T5:   nxt_state = is_muldiv ? ST_T6 : END_STATE;
      ST_T6:   nxt_state = END_STATE;
      ST_HALT: nxt_state = ST_HALT;
`ifdef ALU_SEQ_SINGLE_STEP_EN
      ST_WAIT_STEP: if (step) nxt_state = ST_T0;
`endif
      default: nxt_state = ST_RST;
    endcase
  end

  // Strobes decode from the next state so they are registered for the whole state.
  always_comb begin
    strb_d = '0;
    case (nxt_state)
      ST_T0: begin
        strb_d.pc_out  = 1'b1;
        strb_d.mar_in  = 1'b1;
        strb_d.inc_pc  = 1'b1;
        strb_d.zlow_in = 1'b1;
      end
      ST_T1: begin
        strb_d.zlo_out = 1'b1;
        strb_d.pc_in   = 1'b1;
        strb_d.read    = 1'b1;
        strb_d.mdr_in  = 1'b1;
      end
      ST_T2: begin
        strb_d.mdr_out = 1'b1;
        strb_d.ir_in   = 1'b1;
      end
      ST_T3: strb_d.y_in = 1'b1;
      ST_T4: begin
        strb_d.zlow_in  = 1'b1;
        strb_d.zhigh_in = is_muldiv;
      end
      ST_T5: begin
        strb_d.zlo_out = 1'b1;
        strb_d.lo_in   = is_muldiv;
      end
      ST_T6: begin
        strb_d.zhi_out = 1'b1;
        strb_d.hi_in   = 1'b1;
      end
      default: strb_d = '0;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!clear) begin
      cur_state  <= ST_RST;
      strb_q     <= '0;
      operation  <= '0;
      run        <= 1'b1;
      illegal_op <= 1'b0;
      rb_drv_q   <= 1'b0;
      rc_drv_q   <= 1'b0;
      ra_load_q  <= 1'b0;
    end else begin
      cur_state  <= nxt_state;
      strb_q     <= strb_d;
      if (nxt_state == ST_T4) operation <= opcode;
      run        <= (nxt_state != ST_HALT);
      illegal_op <= (cur_state == ST_T3) && !is_legal;
      rb_drv_q   <= (nxt_state == ST_T3);
      rc_drv_q   <= (nxt_state == ST_T4);
      ra_load_q  <= (nxt_state == ST_T5) && !is_muldiv;
    end
  end

  // Register selects are enabled by flops but index the IR as it stands in the
  // state itself, since the IR is only loaded at the end of T2.
  assign out_idx = rb_drv_q ? rb_idx : rc_idx;

  idx_decoder #(.REG_IDX_W(REG_IDX_W), .NUM_REGS(NUM_REGS)) u_dec_out (
    .idx    (out_idx),
    .en     (rb_drv_q | rc_drv_q),
    .onehot (reg_out)
  );

  idx_decoder #(.REG_IDX_W(REG_IDX_W), .NUM_REGS(NUM_REGS)) u_dec_in (
    .idx    (ra_idx),
    .en     (ra_load_q),
    .onehot (reg_in)
  );

  assign PCout   = strb_q.pc_out;
  assign PCin    = strb_q.pc_in;
  assign IncPC   = strb_q.inc_pc;
  assign MARin   = strb_q.mar_in;
  assign MDRin   = strb_q.mdr_in;
  assign MDRout  = strb_q.mdr_out;
  assign IRin    = strb_q.ir_in;
  assign Yin     = strb_q.y_in;
  assign Zlowin  = strb_q.zlow_in;
  assign Zhighin = strb_q.zhigh_in;
  assign ZLOout  = strb_q.zlo_out;
  assign ZHIout  = strb_q.zhi_out;
  assign HIin    = strb_q.hi_in;
  assign LOin    = strb_q.lo_in;
  assign read    = strb_q.read;
  assign state_q = cur_state;

endmodule

// File: tb/tb_alu_control_sequencer.sv
// Self-checking bench for alu_control_sequencer: per-instruction step plans with
// random stalls, resets and opcodes, plus literal checks of the documented examples.
`timescale 1ns/1ps
module tb_alu_control_sequencer;
  import alu_seq_pkg::*;

  localparam int NR = 16;

  localparam logic [14:0] B_PCOUT   = 15'h4000;
  localparam logic [14:0] B_PCIN    = 15'h2000;
  localparam logic [14:0] B_INCPC   = 15'h1000;
  localparam logic [14:0] B_MARIN   = 15'h0800;
  localparam logic [14:0] B_MDRIN   = 15'h0400;
  localparam logic [14:0] B_MDROUT  = 15'h0200;
  localparam logic [14:0] B_IRIN    = 15'h0100;
  localparam logic [14:0] B_YIN     = 15'h0080;
  localparam logic [14:0] B_ZLOWIN  = 15'h0040;
  localparam logic [14:0] B_ZHIGHIN = 15'h0020;
  localparam logic [14:0] B_ZLOOUT  = 15'h0010;
  localparam logic [14:0] B_ZHIOUT  = 15'h0008;
  localparam logic [14:0] B_HIIN    = 15'h0004;
  localparam logic [14:0] B_LOIN    = 15'h0002;
  localparam logic [14:0] B_READ    = 15'h0001;

  logic clock = 1'b0;
  logic clear, mem_ready;
  logic [31:0] ir;
`ifdef ALU_SEQ_SINGLE_STEP_EN
  logic step;
`endif
  logic [NR-1:0] reg_in, reg_out;
  logic PCout, PCin, IncPC, MARin, MDRin, MDRout, IRin, Yin;
  logic Zlowin, Zhighin, ZLOout, ZHIout, HIin, LOin, read;
  logic [4:0] operation;
  logic run, illegal_op;
  logic [3:0] state_q;

  int tests = 0;
  int fails = 0;
  int cyc = 0;

  logic [4:0] last_op = '0;
  logic       pend_ill = 1'b0;

  logic [3:0]    cap_st[$];
  logic [14:0]   cap_s[$];
  logic [NR-1:0] cap_in[$], cap_out[$];
  logic [4:0]    cap_op[$];
  logic          cap_run[$], cap_ill[$];

  always #5 clock = ~clock;

  alu_control_sequencer dut (
    .clock(clock), .clear(clear), .ir(ir), .mem_ready(mem_ready),
`ifdef ALU_SEQ_SINGLE_STEP_EN
    .step(step),
`endif
    .reg_in(reg_in), .reg_out(reg_out),
    .PCout(PCout), .PCin(PCin), .IncPC(IncPC), .MARin(MARin), .MDRin(MDRin),
    .MDRout(MDRout), .IRin(IRin), .Yin(Yin), .Zlowin(Zlowin), .Zhighin(Zhighin),
    .ZLOout(ZLOout), .ZHIout(ZHIout), .HIin(HIin), .LOin(LOin), .read(read),
    .operation(operation), .run(run), .illegal_op(illegal_op), .state_q(state_q)
  );

  function automatic logic [NR-1:0] onehot(input int idx);
    logic [NR-1:0] v;
    v = '0;
    if (idx < NR) v[idx] = 1'b1;
    return v;
  endfunction

  function automatic logic is_legal(input logic [4:0] op);
    return op inside {OP_ADD, OP_AND, OP_OR, OP_SUB, OP_MUL, OP_DIV, OP_NOP, OP_HALT};
  endfunction

  function automatic logic [31:0] mk(input logic [4:0] op, input int ra, input int rb, input int rc);
    return {op, 4'(ra), 4'(rb), 4'(rc), 15'($urandom)};
  endfunction

  task automatic lit(input string name, input logic [31:0] got, input logic [31:0] want);
    tests++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s got=%h want=%h", name, got, want);
    end
  endtask

  // Check the cycle at hand against the step's documented actions, then drive inputs.
  task automatic tick(input logic [3:0] st, input logic mr, input logic clr, input logic stp);
    logic [4:0] op;
    logic md;
    logic [14:0] es, as;
    logic [NR-1:0] ein, eout;
    logic erun;
    logic [57:0] ev, av;
    op = ir[31:27];
    md = (op == OP_MUL) || (op == OP_DIV);
    es = '0; ein = '0; eout = '0; erun = 1'b1;
    if (st == ST_T4) last_op = op;
    case (st)
      ST_T0: es = B_PCOUT | B_MARIN | B_INCPC | B_ZLOWIN;
      ST_T1: es = B_ZLOOUT | B_PCIN | B_READ | B_MDRIN;
      ST_T2: es = B_MDROUT | B_IRIN;
      ST_T3: begin es = B_YIN; eout = onehot(int'(ir[22:19])); end
      ST_T4: begin es = B_ZLOWIN | (md ? B_ZHIGHIN : 15'h0); eout = onehot(int'(ir[18:15])); end
      ST_T5: begin
        es = B_ZLOOUT | (md ? B_LOIN : 15'h0);
        if (!md) ein = onehot(int'(ir[26:23]));
      end
      ST_T6: es = B_ZHIOUT | B_HIIN;
      ST_HALT: erun = 1'b0;
      default: es = '0;
    endcase
    as = {PCout, PCin, IncPC, MARin, MDRin, MDRout, IRin, Yin, Zlowin, Zhighin,
          ZLOout, ZHIout, HIin, LOin, read};
    ev = {ein, eout, es, last_op, erun, pend_ill, st};
    av = {reg_in, reg_out, as, operation, run, illegal_op, state_q};
    tests++;
    if (av !== ev) begin
      fails++;
      $display("FAIL outputs cycle=%0d step=%0d got=%h want=%h", cyc, st, av, ev);
    end
    cap_st.push_back(state_q); cap_s.push_back(as); cap_in.push_back(reg_in);
    cap_out.push_back(reg_out); cap_op.push_back(operation);
    cap_run.push_back(run); cap_ill.push_back(illegal_op);
    pend_ill = (st == ST_T3) && !is_legal(op);
    if (!clr) begin last_op = '0; pend_ill = 1'b0; end
    mem_ready = mr;
    clear = clr;
`ifdef ALU_SEQ_SINGLE_STEP_EN
    step = stp;
`else
    if (stp) mem_ready = mr;
`endif
    cyc++;
    @(negedge clock);
  endtask

  task automatic wait_step();
`ifdef ALU_SEQ_SINGLE_STEP_EN
    int n;
    n = $urandom_range(0, 3);
    repeat (n) tick(ST_WAIT_STEP, 1'($urandom), 1'b1, 1'b0);
    tick(ST_WAIT_STEP, 1'($urandom), 1'b1, 1'b1);
`endif
  endtask

  // Entered with the sequencer in T0; clr_at is the plan index where clear drops (-1: never).
  task automatic run_instr(input logic [31:0] instr, input int stalls, input int clr_at);
    logic [3:0] plan[$];
    logic [4:0] op;
    logic mr, clr;
    int t1, ca;
    ir = instr;
    op = instr[31:27];
    cap_st.delete(); cap_s.delete(); cap_in.delete(); cap_out.delete();
    cap_op.delete(); cap_run.delete(); cap_ill.delete();
    plan.push_back(ST_T0);
    repeat (stalls + 1) plan.push_back(ST_T1);
    plan.push_back(ST_T2);
    plan.push_back(ST_T3);
    if (op == OP_HALT) begin
      repeat (20) plan.push_back(ST_HALT);
    end else if (is_legal(op) && op != OP_NOP) begin
      plan.push_back(ST_T4);
      plan.push_back(ST_T5);
      if (op == OP_MUL || op == OP_DIV) plan.push_back(ST_T6);
    end
    ca = clr_at;
    if (op == OP_HALT && (ca < 0 || ca >= plan.size())) ca = plan.size() - 1;
    t1 = 0;
    for (int i = 0; i < plan.size(); i++) begin
      mr = 1'($urandom);
      if (plan[i] == ST_T1) begin
        mr = (t1 == stalls);
        t1++;
      end
      clr = (i != ca);
      tick(plan[i], mr, clr, 1'b0);
      if (!clr) begin
        tick(ST_RST, 1'($urandom), 1'b1, 1'b0);
        wait_step();
        return;
      end
    end
    wait_step();
  endtask

  initial begin
    logic [14:0] acc;
    logic early, any_in;
    int nhalt;
    logic [4:0] ops[11];
    ops = '{OP_ADD, OP_AND, OP_OR, OP_SUB, OP_MUL, OP_DIV, OP_NOP, OP_HALT,
            5'b11111, 5'b00000, 5'b01010};
    clear = 1'b0; mem_ready = 1'b1; ir = '0;
`ifdef ALU_SEQ_SINGLE_STEP_EN
    step = 1'b0;
`endif
    repeat (2) @(negedge clock);
    lit("reset_run", {31'd0, run}, 32'd1);
    tick(ST_RST, 1'b1, 1'b1, 1'b0);
    wait_step();

    // AND R0,R4,R5
    run_instr(32'h2022_8000, 0, -1);
    lit("and_t3_reg_out", cap_out[3], 32'h0010);
    lit("and_t3_yin", cap_s[3] & B_YIN, B_YIN);
    lit("and_t4_reg_out", cap_out[4], 32'h0020);
    lit("and_t4_op", cap_op[4], 32'h04);
    lit("and_t4_zlowin", cap_s[4] & B_ZLOWIN, B_ZLOWIN);
    lit("and_t5_zloout", cap_s[5] & B_ZLOOUT, B_ZLOOUT);
    lit("and_t5_reg_in", cap_in[5], 32'h0001);
    lit("and_back_t0", state_q, ST_T0);

    // MUL R1,R2,R3
    run_instr(mk(OP_MUL, 1, 2, 3), 0, -1);
    lit("mul_t4_zlo_zhi", cap_s[4] & (B_ZLOWIN | B_ZHIGHIN), B_ZLOWIN | B_ZHIGHIN);
    lit("mul_t5_loin", cap_s[5] & B_LOIN, B_LOIN);
    lit("mul_t6_zhi_hi", cap_s[6] & (B_ZHIOUT | B_HIIN), B_ZHIOUT | B_HIIN);
    any_in = 1'b0;
    foreach (cap_in[i]) any_in |= |cap_in[i];
    lit("mul_no_reg_in", any_in, 0);

    // 3-cycle memory stall
    run_instr(mk(OP_ADD, 2, 3, 4), 3, -1);
    acc = B_READ | B_MDRIN | B_PCIN;
    early = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      acc &= cap_s[i];
      early |= cap_s[i][8];
    end
    lit("stall_t1_strobes", acc, B_READ | B_MDRIN | B_PCIN);
    lit("stall_irin_early", early, 0);
    lit("stall_t2_irin", cap_s[5] & B_IRIN, B_IRIN);

    // clear during a T1 stall, then during T4
    run_instr(mk(OP_ADD, 5, 6, 7), 3, 2);
    lit("clr_stall_rst", cap_st[3], ST_RST);
    lit("clr_stall_quiet", cap_s[3], 0);
    lit("clr_stall_t0", state_q, ST_T0);
    run_instr(mk(OP_SUB, 1, 1, 2), 0, 4);
    lit("clr_t4_rst", cap_st[5], ST_RST);
    lit("clr_t4_op_zero", cap_op[5], 0);

    // illegal opcode 11111
    run_instr(mk(5'b11111, 3, 4, 5), 0, -1);
    any_in = 1'b0;
    foreach (cap_in[i]) any_in |= |cap_in[i];
    lit("illegal_no_reg_in", any_in, 0);
`ifdef ALU_SEQ_SINGLE_STEP_EN
    lit("illegal_pulse", cap_ill[4], 1);
`else
    lit("illegal_pulse", illegal_op, 1);
`endif

    // HALT holds run low for 20 cycles, then reset
    run_instr(mk(OP_HALT, 0, 0, 0), 0, -1);
    nhalt = 0;
    foreach (cap_run[i]) if (cap_run[i] == 1'b0) nhalt++;
    lit("halt_run_low", nhalt, 20);

    for (int n = 0; n < 80; n++) begin
      logic [4:0] op;
      int ca;
      op = ops[$urandom_range(0, 10)];
      ca = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 5)) : -1;
      run_instr(mk(op, $urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 15)),
                $urandom_range(0, 3), ca);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
